// File: rtl/mult_seq.sv
// mult_seq: 32x32 sequential shift-add multiplier, signed or unsigned, fixed 34-cycle latency
module mult_seq (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic        sign,
   input  logic [31:0] A,
   input  logic [31:0] B,
   output logic        busy,
   output logic        done,
   output logic [31:0] outHigh,
   output logic [31:0] outLow,
   output logic        Z,
   output logic        N,
   output logic        C,
   output logic        V
);
   localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, FIX = 2'd2, DONE = 2'd3;
   logic [1:0]  state;
   logic        sign_l, res_neg;
   logic [31:0] a_mag, b_mag;
   logic [63:0] acc, prod;
   logic [4:0]  count;
   assign prod = res_neg ? -acc : acc;
   assign busy = state != IDLE;
   assign done = state == DONE;
   assign C    = 1'b0;
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         state   <= IDLE;
         sign_l  <= 1'b0;
         res_neg <= 1'b0;
         a_mag   <= '0;
         b_mag   <= '0;
         acc     <= '0;
         count   <= '0;
         outHigh <= '0;
         outLow  <= '0;
         Z       <= 1'b0;
         N       <= 1'b0;
         V       <= 1'b0;
      end else
         case (state)
            IDLE: if (start) begin
               state   <= RUN;
               sign_l  <= sign;
               // negating 0x80000000 yields 0x80000000, read as unsigned 2^31
               a_mag   <= (sign & A[31]) ? -A : A;
               b_mag   <= (sign & B[31]) ? -B : B;
               res_neg <= sign & (A[31] ^ B[31]);
               acc     <= '0;
               count   <= '0;
            end
            RUN: begin
               if (b_mag[count]) acc <= acc + ({32'd0, a_mag} << count);
               count <= count + 5'd1;
               if (count == 5'd31) state <= FIX;
            end
            FIX: begin
               {outHigh, outLow} <= prod;
               Z     <= prod == 64'd0;
               N     <= sign_l & prod[63];
               V     <= sign_l ? (prod[63:32] != {32{prod[31]}}) : (prod[63:32] != 32'd0);
               state <= DONE;
            end
            default: state <= IDLE;
         endcase
endmodule

// File: tb/tb_mult_seq.sv
// tb_mult_seq: directed vectors for mult_seq against an arithmetic reference model
module tb_mult_seq;
   logic        clk = 1'b0, reset = 1'b1, start = 1'b0, sign = 1'b0;
   logic [31:0] A = '0, B = '0;
   logic        busy, done, Z, N, C, V;
   logic [31:0] outHigh, outLow;
   int vecs = 0, errs = 0, done_cnt = 0;

   mult_seq dut (.clk(clk), .reset(reset), .start(start), .sign(sign), .A(A), .B(B),
                 .busy(busy), .done(done), .outHigh(outHigh), .outLow(outLow),
                 .Z(Z), .N(N), .C(C), .V(V));

   always #5 clk = ~clk;

   // model: t counts edges since acceptance (0 = idle); result appears on the 34th edge
   int          t = 0;
   logic [63:0] mp = '0, pend = '0;
   logic        mz = 0, mn = 0, mv = 0, pz = 0, pn = 0, pv = 0;

   function automatic logic [63:0] product(input logic s, input logic [31:0] a, input logic [31:0] b);
      longint sa, sb;
      sa = s ? longint'($signed(a)) : longint'({32'd0, a});
      sb = s ? longint'($signed(b)) : longint'({32'd0, b});
      return 64'(sa * sb);
   endfunction

   always @(posedge clk or posedge reset)
      if (reset) begin
         t = 0; mp = '0; mz = 0; mn = 0; mv = 0;
      end else if (t == 0) begin
         if (start) begin
            t = 1;
            pend = product(sign, A, B);
            pz = pend == 64'd0;
            pn = sign & pend[63];
            pv = sign ? (pend[63:32] != {32{pend[31]}}) : (pend[63:32] != 32'd0);
         end
      end else begin
         t = t + 1;
         if (t == 34) begin mp = pend; mz = pz; mn = pn; mv = pv; end
         else if (t == 35) t = 0;
      end

   task automatic chk(input string name, input logic [69:0] act, input logic [69:0] exp);
      vecs++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (done) done_cnt++;
      chk("cycle", {busy, done, outHigh, outLow, Z, N, C, V},
          {t != 0, t == 34, mp, mz, mn, 1'b0, mv});
   end

   task automatic run(input logic s, input logic [31:0] a, input logic [31:0] b,
                      input logic [63:0] ep, input logic ez, input logic en, input logic ev,
                      input bit restart);
      int n, d0;
      @(negedge clk);
      d0 = done_cnt;
      sign = s; A = a; B = b; start = 1'b1;
      @(negedge clk);
      start = 1'b0; sign = ~s; A = $urandom; B = $urandom;
      n = 1;
      while (!done && n < 100) begin
         @(negedge clk);
         n++;
         start = restart && n == 5;
      end
      start = 1'b0;
      chk("latency", 70'(n), 70'd34);
      chk("result", {2'b00, outHigh, outLow, Z, N, C, V}, {2'b00, ep, ez, en, 1'b0, ev});
      repeat (5) @(negedge clk);
      chk("done_pulses", 70'(done_cnt - d0), 70'd1);
      sign = 1'b0;
   endtask

   initial begin
      repeat (2) @(negedge clk);
      chk("reset_state", {busy, done, outHigh, outLow, Z, N, C, V}, 70'd0);
      reset = 1'b0;
      run(0, 32'hFFFFFFFB, 32'h00000001, 64'h00000000_FFFFFFFB, 0, 0, 0, 0);
      run(1, 32'hFFFFFFFB, 32'h00000001, 64'hFFFFFFFF_FFFFFFFB, 0, 1, 0, 0);
      run(0, 32'h00000000, 32'h12345678, 64'h0, 1, 0, 0, 1);
      run(0, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001, 0, 0, 1, 0);
      run(1, 32'h80000000, 32'h80000000, 64'h40000000_00000000, 0, 0, 1, 0);
      run(1, 32'h00000007, 32'hFFFFFFFD, 64'hFFFFFFFF_FFFFFFEB, 0, 1, 0, 0);
      begin
         int d0;
         d0 = done_cnt;
         @(negedge clk);
         sign = 1'b0; A = 32'hDEADBEEF; B = 32'h0000FFFF; start = 1'b1;
         @(negedge clk);
         start = 1'b0;
         repeat (10) @(negedge clk);
         #2 reset = 1'b1;
         #1 chk("reset_async", {busy, done, outHigh, outLow, Z, N, C, V}, 70'd0);
         @(negedge clk);
         reset = 1'b0;
         repeat (40) @(negedge clk);
         chk("no_done_after_abort", 70'(done_cnt - d0), 70'd0);
      end
      run(0, 32'd1000, 32'd1000, 64'd1000000, 0, 0, 0, 0);
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end
endmodule

// File: doc/mult_seq.md
MULT_SEQ -- requirements
Module: mult_seq

Interface
REQ-001 The block SHALL take one clock and an asynchronous, active-high reset, ports named clk and reset.
REQ-002 Port clk, input, 1, rising-edge system clock.
REQ-003 Port reset, input, 1, asynchronous active-high reset.
REQ-004 Port start, input, 1, request pulse or level, sampled only in IDLE.
REQ-005 Port sign, input, 1, 1 = two's-complement operands, 0 = unsigned; sampled with start.
REQ-006 Port A, input, 32, multiplicand; sampled with start.
REQ-007 Port B, input, 32, multiplier; sampled with start.
REQ-008 Port busy, output, 1, high in every state except IDLE.
REQ-009 Port done, output, 1, one-cycle pulse when the result is valid.
REQ-010 Port outHigh, output, 32, product bits 63:32.
REQ-011 Port outLow, output, 32, product bits 31:0.
REQ-012 Ports Z, N, C, V, output, 1 each: zero, negative, carry and overflow flags.

Function
REQ-013 The FSM SHALL have four states: IDLE, RUN, FIX and DONE, encoded as a registered state variable.
REQ-014 IDLE: start=1 at a rising edge SHALL do all of the following, then enter RUN:
- latch sign;
- latch |A| and |B| (magnitudes only when sign=1; raw values when sign=0);
- latch res_neg = sign & (A[31] ^ B[31]);
- clear the 64-bit accumulator and the 5-bit counter.
REQ-015 RUN: each cycle SHALL execute one shift-add step on multiplier bit [count]:
- add the multiplicand magnitude, shifted left by count, into the 64-bit accumulator;
- increment count.
REQ-016 RUN SHALL exit to FIX after exactly 32 cycles, on the edge where count wraps from 31 to 0.
REQ-017 The magnitude of 0x80000000 with sign=1 SHALL be 0x80000000, treated as unsigned 2^31.
REQ-018 FIX: one cycle; on its exit edge the block SHALL:
- set the product to the two's-complement negation of the accumulator if res_neg, else the accumulator;
- register the product into {outHigh,outLow};
- update the flags;
- enter DONE.
REQ-019 DONE: done=1 for exactly one cycle, then unconditional return to IDLE.
REQ-020 Latency SHALL be fixed: done is high in the 34th cycle after the accepting edge (the cycle following the 34th rising edge, counting the accepting edge), independent of operand values.
REQ-021 start in RUN, FIX or DONE SHALL be ignored and SHALL NOT be queued.
REQ-022 A, B and sign changes after the accepting edge SHALL NOT affect the in-flight result.
REQ-023 outHigh, outLow, Z, N, C and V SHALL hold their last values until the next FIX exit edge.
REQ-024 Z SHALL be 1 iff the 64-bit product is 0.
REQ-025 N SHALL equal sign & product[63]; N SHALL be 0 for unsigned operations.
REQ-026 C SHALL always be 0.
REQ-027 V SHALL flag a product that does not fit in 32 bits:
- sign=0: V = (outHigh != 0);
- sign=1: V = (outHigh != {32{outLow[31]}}).
REQ-028 done and busy SHALL be driven from registered state, with no combinational path from start.

Reset
REQ-029 reset=1 SHALL immediately force the following, regardless of clk:
- state IDLE;
- busy=0, done=0;
- outHigh=0, outLow=0;
- Z=0, N=0, C=0, V=0;
- accumulator, counter, res_neg and latched operands to 0.
REQ-030 Reset asserted mid-operation SHALL abort the operation, with no done pulse and no output update.
REQ-031 Reset SHALL have priority over start at the same edge; the first start is accepted at the first rising edge with reset=0.

Verification
REQ-032 The bench SHALL cover these scenarios:
- unsigned 0xFFFFFFFB x 0x00000001 -> outHigh=0x00000000, outLow=0xFFFFFFFB, Z=0 N=0 V=0 C=0, done 34 cycles after start.
- signed 0xFFFFFFFB (-5) x 0x00000001 -> outHigh=0xFFFFFFFF, outLow=0xFFFFFFFB, N=1 V=0 Z=0.
- unsigned 0xFFFFFFFF x 0xFFFFFFFF -> outHigh=0xFFFFFFFE, outLow=0x00000001, V=1 N=0.
- signed 0x80000000 x 0x80000000 -> outHigh=0x40000000, outLow=0x00000000, N=0 V=1.
- unsigned 0x00000000 x 0x12345678 -> result 0, Z=1; a second start pulsed 5 cycles after the first is ignored, with exactly one done pulse.
- reset asserted during RUN cycle 10 -> busy=0 and all outputs 0 at once, no done; a new start after deassert completes normally.
